dff_bank_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for a shared W-bit D-flip-flop register between N requesters.
- Each requester raises req with its data. The arbiter grants one requester per write, loads that requester's data into the shared register, and pulses q_valid.
- A bounded lock lets a requester perform back-to-back writes without re-arbitration.
- Sits between requester logic and the shared flop bank; it is the only writer of that bank.

---
 rtl/dff_bank_arbiter_pkg.sv | 14 +
 rtl/dff_bank_arbiter_if.sv | 29 ++
 rtl/dff_bank_arbiter_rr_pick.sv | 25 ++
 rtl/dff_bank_arbiter.sv | 98 +++++++++
 tb/tb_dff_bank_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
package dff_bank_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the arbiter: requests, lock hints, data lanes and results.
interface dff_bank_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    import dff_bank_arbiter_pkg::*;

    localparam int unsigned OW = idx_w(N);

    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [OW-1:0]  owner;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           busy;

    modport master (
        output req, lock, wdata,
        input  gnt, owner, q, q_valid, busy
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, owner, q, q_valid, busy
    );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping at N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned OW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [OW-1:0] ptr_i,
    output logic          valid_o,
    output logic [OW-1:0] win_o
);

    always_comb begin
        valid_o = 1'b0;
        win_o   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            int unsigned idx;
            idx = (32'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                win_o   = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and sole writer of a shared W-bit register, with a bounded grant lock.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_LOCK = 3
) (
    input  logic              clk,
    input  logic              reset,
    dff_bank_arbiter_if.slave bus
);

    localparam int unsigned OW = idx_w(N);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [LW-1:0] lockcnt_q, lockcnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          qv_q, qv_d;

    logic          pick_valid;
    logic [OW-1:0] pick_win;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (owner_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        lockcnt_d = lockcnt_q;
        q_d       = q_q;
        qv_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    gnt_d[pick_win] = 1'b1;
                    owner_d         = pick_win;
                    lockcnt_d       = LW'(1);
                    state_d         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.req[owner_q]) begin
                    q_d  = bus.wdata[32'(owner_q)*W +: W];
                    qv_d = 1'b1;
                end
                // Lock only extends a live request, and only up to the cap.
                if (bus.req[owner_q] && bus.lock[owner_q] && (lockcnt_q < LW'(MAX_LOCK))) begin
                    lockcnt_d = lockcnt_q + LW'(1);
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= OW'(N - 1);
            lockcnt_q <= '0;
            q_q       <= '0;
            qv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            lockcnt_q <= lockcnt_d;
            q_q       <= q_d;
            qv_q      <= qv_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.q       = q_q;
    assign bus.q_valid = qv_q;
    assign bus.busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed, table-driven bench for dff_bank_arbiter (N=4, W=8, MAX_LOCK=3).
module tb_dff_bank_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.N(4), .W(8)) bus ();

    dff_bank_arbiter #(
        .N        (4),
        .W        (8),
        .MAX_LOCK (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  q;
        logic        qv;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [31:0] wd, input logic [3:0] g, input logic [1:0] o,
                       input logic [7:0] qq, input logic qv, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.wdata = wd;
        v.gnt = g; v.owner = o; v.q = qq; v.qv = qv; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] g, input logic [1:0] o,
                       input logic [7:0] qq, input logic qv, input logic b);
        checks++;
        if ({bus.gnt, bus.owner, bus.q, bus.q_valid, bus.busy} !== {g, o, qq, qv, b}) begin
            failures++;
            $display("FAIL %s: got gnt=%b owner=%0d q=%h q_valid=%b busy=%b, want gnt=%b owner=%0d q=%h q_valid=%b busy=%b",
                     nm, bus.gnt, bus.owner, bus.q, bus.q_valid, bus.busy, g, o, qq, qv, b);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            assert ($onehot0(bus.gnt)) else begin
                failures++;
                $display("FAIL gnt_onehot: got gnt=%b, want one-hot or zero", bus.gnt);
            end
        end
    end

    initial begin
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;

        // Startup: test A, then (after reset) round robin, lock cap with
        // mid-grant data change, withdrawn request, wrap-around.
        add(0, 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 2'd0, 8'h00, 0, 1);
        add(0, 4'b0001, 4'b0000, 32'h000000A5, 4'b0000, 2'd0, 8'hA5, 1, 0);
        add(0, 4'b0000, 4'b0000, 32'h000000A5, 4'b0000, 2'd0, 8'hA5, 0, 0);

        add(1, 4'b1111, 4'b0000, 32'h43322110, 4'b0001, 2'd0, 8'h00, 0, 1);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0000, 2'd0, 8'h10, 1, 0);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0010, 2'd1, 8'h10, 0, 1);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0000, 2'd1, 8'h21, 1, 0);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0100, 2'd2, 8'h21, 0, 1);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0000, 2'd2, 8'h32, 1, 0);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b1000, 2'd3, 8'h32, 0, 1);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0000, 2'd3, 8'h43, 1, 0);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0001, 2'd0, 8'h43, 0, 1);
        add(0, 4'b1111, 4'b0000, 32'h43322110, 4'b0000, 2'd0, 8'h10, 1, 0);
        add(0, 4'b0000, 4'b0000, 32'h43322110, 4'b0000, 2'd0, 8'h10, 0, 0);

        add(0, 4'b0011, 4'b0010, 32'h43326B5A, 4'b0010, 2'd1, 8'h10, 0, 1);
        add(0, 4'b0011, 4'b0010, 32'h43326B5A, 4'b0010, 2'd1, 8'h6B, 1, 1);
        add(0, 4'b0011, 4'b0010, 32'h43327C5A, 4'b0010, 2'd1, 8'h7C, 1, 1);
        add(0, 4'b0011, 4'b0010, 32'h43327C5A, 4'b0000, 2'd1, 8'h7C, 1, 0);
        add(0, 4'b0011, 4'b0000, 32'h43327C5A, 4'b0001, 2'd0, 8'h7C, 0, 1);
        add(0, 4'b0011, 4'b0000, 32'h43327C5A, 4'b0000, 2'd0, 8'h5A, 1, 0);
        add(0, 4'b0000, 4'b0000, 32'h43327C5A, 4'b0000, 2'd0, 8'h5A, 0, 0);

        add(0, 4'b0100, 4'b0000, 32'h43327C5A, 4'b0100, 2'd2, 8'h5A, 0, 1);
        add(0, 4'b0000, 4'b0000, 32'h43327C5A, 4'b0000, 2'd2, 8'h5A, 0, 0);
        add(0, 4'b0000, 4'b0000, 32'h43327C5A, 4'b0000, 2'd2, 8'h5A, 0, 0);

        add(0, 4'b1000, 4'b0000, 32'h43327C5A, 4'b1000, 2'd3, 8'h5A, 0, 1);
        add(0, 4'b1000, 4'b0000, 32'h43327C5A, 4'b0000, 2'd3, 8'h43, 1, 0);
        add(0, 4'b1001, 4'b0000, 32'h43327C5A, 4'b0001, 2'd0, 8'h43, 0, 1);

        // Held in reset with random traffic: outputs must stay at reset values.
        for (int i = 0; i < 3; i++) begin
            bus.req   = 4'($urandom);
            bus.lock  = 4'($urandom);
            bus.wdata = $urandom;
            @(posedge clk); #1;
            chk("reset_hold", 4'b0000, 2'd3, 8'h00, 0, 0);
        end
        bus.req  = '0;
        bus.lock = '0;
        reset    = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
            bus.req   = vecs[i].req;
            bus.lock  = vecs[i].lock;
            bus.wdata = vecs[i].wdata;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].q,
                vecs[i].qv, vecs[i].busy);
        end

        // Requester 0 holds GRANT after the wrap; reset must clear it between edges.
        #3 reset = 1'b0;
        #1 chk("midreset_wrap", 4'b0000, 2'd3, 8'h00, 0, 0);
        bus.req = '0;
        #1 reset = 1'b1;

        // Locked grant with q_valid high, then reset between edges.
        @(posedge clk); #1;
        bus.req   = 4'b0001;
        bus.lock  = 4'b0001;
        bus.wdata = 32'h0000005A;
        @(posedge clk); #1;
        chk("lock0_grant", 4'b0001, 2'd0, 8'h00, 0, 1);
        @(posedge clk); #1;
        chk("lock0_write", 4'b0001, 2'd0, 8'h5A, 1, 1);
        #3 reset = 1'b0;
        #1 chk("midreset_lock", 4'b0000, 2'd3, 8'h00, 0, 0);
        bus.req  = '0;
        bus.lock = '0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 4'b0000, 2'd3, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
